decode_stage_hz: RTL

Parametrised RV32I decode stage: decodes the instruction word, reads a NREGS×XLEN register file with optional write-through bypass, builds the immediate, detects load-use hazards and registers everything into the ID/EX pipeline register with bubble/flush support. It sits between the IF/ID register and the execute stage and drives the hazard stall back to fetch.

---
 rtl/decode_stage_hz.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/decode_stage_hz.sv
// RV32I decode stage: control decode, register file, immediate build, load-use hazard and ID/EX register.
// Optional write-through read bypass enabled by defining DECODE_WB_BYPASS_EN.
module decode_stage_hz #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [31:0]     InstrD,
   input  logic            ValidD,
   input  logic [XLEN-1:0] PCD,
   input  logic [XLEN-1:0] PCPlus4D,
   input  logic            we3,
   input  logic [AW-1:0]   RdW,
   input  logic [XLEN-1:0] a3,
   input  logic            FlushE,
   output logic            StallD,
   output logic            ValidE,
   output logic            MemReadE,
   output logic            MemWriteE,
   output logic            ALUSrcE,
   output logic            JumpE,
   output logic            RegWriteE,
   output logic            BranchE,
   output logic            MuxjalrE,
   output logic [3:0]      ALUOpE,
   output logic [2:0]      ImmControlE,
   output logic [2:0]      WriteBackE,
   output logic [2:0]      funct3E,
   output logic [XLEN-1:0] RD1E,
   output logic [XLEN-1:0] RD2E,
   output logic [XLEN-1:0] PCE,
   output logic [XLEN-1:0] ImmExtE,
   output logic [XLEN-1:0] PCPlus4E,
   output logic [AW-1:0]   RdE,
   output logic [AW-1:0]   Rs1E,
   output logic [AW-1:0]   Rs2E
);

   logic [6:0]      opcode;
   logic [2:0]      f3;
   logic            known, use1, use2;
   logic            mem_read, mem_write, alu_src, jump, reg_write, branch, muxjalr;
   logic [3:0]      alu_op;
   logic [2:0]      imm_ctl, wb_sel;
   logic [31:0]     imm32;
   logic [XLEN-1:0] imm_ext, rd1, rd2;
   logic [AW-1:0]   rs1_d, rs2_d, rd_d;
   logic [XLEN-1:0] regs [NREGS];
   logic            load_ok;

   assign opcode = InstrD[6:0];
   assign f3     = InstrD[14:12];

   always_comb begin
      known = 1'b0; use1 = 1'b0; use2 = 1'b0;
      mem_read = 1'b0; mem_write = 1'b0; alu_src = 1'b0; jump = 1'b0;
      reg_write = 1'b0; branch = 1'b0; muxjalr = 1'b0;
      alu_op = 4'b0000; imm_ctl = 3'd0; wb_sel = 3'd0;
      case (opcode)
         7'b0110011: begin
            known = 1'b1; reg_write = 1'b1; use1 = 1'b1; use2 = 1'b1;
            alu_op = {InstrD[30], f3};
         end
         7'b0010011: begin
            known = 1'b1; reg_write = 1'b1; alu_src = 1'b1; use1 = 1'b1;
            alu_op = {InstrD[30] & (f3 == 3'b101), f3};
         end
         7'b0000011: begin
            known = 1'b1; reg_write = 1'b1; alu_src = 1'b1; use1 = 1'b1;
            mem_read = 1'b1; wb_sel = 3'd1;
         end
         7'b0100011: begin
            known = 1'b1; alu_src = 1'b1; mem_write = 1'b1; use1 = 1'b1; use2 = 1'b1;
            imm_ctl = 3'd1;
         end
         7'b1100011: begin
            known = 1'b1; branch = 1'b1; use1 = 1'b1; use2 = 1'b1;
            alu_op = 4'b1000; imm_ctl = 3'd2;
         end
         7'b1101111: begin
            known = 1'b1; reg_write = 1'b1; jump = 1'b1; wb_sel = 3'd2; imm_ctl = 3'd4;
         end
         7'b1100111: begin
            known = 1'b1; reg_write = 1'b1; jump = 1'b1; alu_src = 1'b1; muxjalr = 1'b1;
            use1 = 1'b1; wb_sel = 3'd2;
         end
         7'b0110111, 7'b0010111: begin
            known = 1'b1; reg_write = 1'b1; alu_src = 1'b1; imm_ctl = 3'd3;
         end
         default: known = 1'b0;
      endcase
   end

   always_comb begin
      case (imm_ctl)
         3'd1:    imm32 = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
         3'd2:    imm32 = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
         3'd3:    imm32 = {InstrD[31:12], 12'b0};
         3'd4:    imm32 = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
         default: imm32 = {{20{InstrD[31]}}, InstrD[31:20]};
      endcase
   end

   assign imm_ext = XLEN'($signed(imm32));

   // Unused source fields are forced to x0 so they read 0 and never trigger a hazard.
   assign rs1_d = use1 ? InstrD[15 +: AW] : '0;
   assign rs2_d = use2 ? InstrD[20 +: AW] : '0;
   assign rd_d  = reg_write ? InstrD[7 +: AW] : '0;

   always_comb begin
      rd1 = (rs1_d == '0) ? '0 : regs[rs1_d];
      rd2 = (rs2_d == '0) ? '0 : regs[rs2_d];
`ifdef DECODE_WB_BYPASS_EN
      if (we3 && (RdW != '0) && (RdW == rs1_d)) rd1 = a3;
      if (we3 && (RdW != '0) && (RdW == rs2_d)) rd2 = a3;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (we3 && (RdW != '0)) begin
         regs[RdW] <= a3;
      end
   end

   assign StallD = ValidD & MemReadE & (RdE != '0) &
                   ((use1 & (rs1_d == RdE)) | (use2 & (rs2_d == RdE)));

   assign load_ok = ValidD & known;

   always_ff @(posedge clk) begin
      if (reset || FlushE || StallD || !load_ok) begin
         ValidE <= 1'b0; MemReadE <= 1'b0; MemWriteE <= 1'b0; ALUSrcE <= 1'b0;
         JumpE <= 1'b0; RegWriteE <= 1'b0; BranchE <= 1'b0; MuxjalrE <= 1'b0;
         ALUOpE <= '0; ImmControlE <= '0; WriteBackE <= '0; funct3E <= '0;
         RD1E <= '0; RD2E <= '0; PCE <= '0; ImmExtE <= '0; PCPlus4E <= '0;
         RdE <= '0; Rs1E <= '0; Rs2E <= '0;
      end else begin
         ValidE <= 1'b1; MemReadE <= mem_read; MemWriteE <= mem_write; ALUSrcE <= alu_src;
         JumpE <= jump; RegWriteE <= reg_write; BranchE <= branch; MuxjalrE <= muxjalr;
         ALUOpE <= alu_op; ImmControlE <= imm_ctl; WriteBackE <= wb_sel; funct3E <= f3;
         RD1E <= rd1; RD2E <= rd2; PCE <= PCD; ImmExtE <= imm_ext; PCPlus4E <= PCPlus4D;
         RdE <= rd_d; Rs1E <= rs1_d; Rs2E <= rs2_d;
      end
   end

endmodule
